// File: rtl/cpu_clk_ctrl.sv
// Run/step/halt CPU clock-enable controller fed by the divided clock.
// Optional breakpoint halt is compiled in with BREAKPOINT_EN.
module cpu_clk_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             div_clk,
   input  logic             run_sw,
   input  logic             step_btn,
   input  logic             halt_req,
   input  logic             clr_halt,
`ifdef BREAKPOINT_EN
   input  logic             bp_en,
   input  logic [31:0]      bp_addr,
   input  logic [31:0]      pc,
   output logic             bp_hit,
`endif
   output logic             cpu_ce,
   output logic             halted,
   output logic             running,
   output logic [CNT_W-1:0] cycle_count
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] HALT = 2'd2;

   logic [1:0]    state, state_n;
   logic          d1, d2, d3;
   logic          b1, b2;
   logic          stable, stable_d;
   logic [DW-1:0] db_cnt;
   logic          step_pending, pend_n;
   logic          ce_n;
   logic          div_edge, step_pulse;

   assign div_edge   = d2 & ~d3;
   assign step_pulse = stable & ~stable_d;

`ifdef BREAKPOINT_EN
   logic bp_trip, hit_n;
   assign bp_trip = cpu_ce && bp_en && (pc == bp_addr) && (state != HALT);
   assign hit_n   = (bp_hit & ~clr_halt) | bp_trip;
`endif

   always_comb begin
      state_n = state;
      ce_n    = 1'b0;
      pend_n  = step_pending;
      case (state)
         IDLE: begin
            if (halt_req) begin
               state_n = HALT;
               pend_n  = 1'b0;
            end else if (run_sw) begin
               state_n = RUN;
               pend_n  = 1'b0;
            end else if (step_pending) begin
               ce_n   = 1'b1;
               pend_n = 1'b0;
            end else if (step_pulse) begin
               pend_n = 1'b1;
            end
         end
         RUN: begin
            pend_n = 1'b0;
            if (halt_req)     state_n = HALT;
            else if (!run_sw) state_n = IDLE;
            else              ce_n    = div_edge;
         end
         HALT: begin
            pend_n = 1'b0;
            if (!halt_req && clr_halt) state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
            pend_n  = 1'b0;
         end
      endcase
`ifdef BREAKPOINT_EN
      // the matched cycle already executed; stop before the next one
      if (bp_trip) begin
         state_n = HALT;
         ce_n    = 1'b0;
         pend_n  = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         d1 <= 1'b0;
         d2 <= 1'b0;
         d3 <= 1'b0;
         b1 <= 1'b0;
         b2 <= 1'b0;
         stable   <= 1'b0;
         stable_d <= 1'b0;
         db_cnt   <= '0;
      end else begin
         d1 <= div_clk;
         d2 <= d1;
         d3 <= d2;
         b1 <= step_btn;
         b2 <= b1;
         stable_d <= stable;
         if (b2 == stable) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_MAX) begin
            stable <= b2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + DW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         step_pending <= 1'b0;
         cpu_ce       <= 1'b0;
         halted       <= 1'b0;
         running      <= 1'b0;
         cycle_count  <= '0;
`ifdef BREAKPOINT_EN
         bp_hit       <= 1'b0;
`endif
      end else begin
         state        <= state_n;
         step_pending <= pend_n;
         cpu_ce       <= ce_n;
         halted       <= (state_n == HALT);
         running      <= (state_n == RUN);
         cycle_count  <= cycle_count + CNT_W'(cpu_ce);
`ifdef BREAKPOINT_EN
         bp_hit       <= hit_n;
`endif
      end
   end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl: reset, free-run, halt, step, wrap.
// Breakpoint steps are included when BREAKPOINT_EN is defined.
module tb_cpu_clk_ctrl;

   localparam int DB = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          div_clk = 1'b0;
   logic          run_sw = 1'b0;
   logic          step_btn = 1'b0;
   logic          halt_req = 1'b0;
   logic          clr_halt = 1'b0;
   logic          cpu_ce, halted, running;
   logic [CW-1:0] cycle_count;
`ifdef BREAKPOINT_EN
   logic          bp_en = 1'b0;
   logic [31:0]   bp_addr = 32'h0;
   logic [31:0]   pc = 32'h0;
   logic          bp_hit;
`endif

   int errors = 0;
   int checks = 0;
   int seen;
   int c;

   cpu_clk_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(CW)) dut (
      .clk(clk),
      .rst(rst),
      .div_clk(div_clk),
      .run_sw(run_sw),
      .step_btn(step_btn),
      .halt_req(halt_req),
      .clr_halt(clr_halt),
`ifdef BREAKPOINT_EN
      .bp_en(bp_en),
      .bp_addr(bp_addr),
      .pc(pc),
      .bp_hit(bp_hit),
`endif
      .cpu_ce(cpu_ce),
      .halted(halted),
      .running(running),
      .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic count_ce(input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         tick();
         if (cpu_ce) cnt++;
      end
   endtask

   // one div_clk period (4 high, 4 low); enable expected 3 clk after rise
   task automatic div_pulse(input string tag);
      div_clk = 1'b1;
      tick();
      tick();
      chk({tag, "_ce_early"}, 32'(cpu_ce), 0);
      tick();
      chk({tag, "_ce"}, 32'(cpu_ce), 1);
      tick();
      div_clk = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      // reset with div_clk toggling
      div_clk = 1'b1;
      tick();
      div_clk = 1'b0;
      tick();
      chk("rst_ce", 32'(cpu_ce), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_running", 32'(running), 0);
      chk("rst_count", 32'(cycle_count), 0);
      rst = 1'b1;
      tick();
      tick();
      chk("idle_running", 32'(running), 0);

      // free-run
      run_sw = 1'b1;
      tick();
      chk("run_enter", 32'(running), 1);
      for (int i = 0; i < 5; i++) div_pulse("run");
      chk("run_count", 32'(cycle_count), 5);

      // halt coincident with div_edge
      div_clk = 1'b1;
      tick();
      tick();
      halt_req = 1'b1;
      tick();
      chk("halt_ce", 32'(cpu_ce), 0);
      chk("halt_halted", 32'(halted), 1);
      chk("halt_running", 32'(running), 0);
      halt_req = 1'b0;
      tick();
      div_clk = 1'b0;
      repeat (4) tick();
      seen = 0;
      for (int k = 0; k < 2; k++) begin
         div_clk = 1'b1;
         count_ce(4, c);
         seen += c;
         div_clk = 1'b0;
         count_ce(4, c);
         seen += c;
      end
      chk("halt_no_ce", 32'(seen), 0);
      chk("halt_count", 32'(cycle_count), 5);
      chk("halt_sticky", 32'(halted), 1);
      clr_halt = 1'b1;
      tick();
      clr_halt = 1'b0;
      chk("clr_halted", 32'(halted), 0);
      chk("clr_idle", 32'(running), 0);
      tick();
      chk("clr_run", 32'(running), 1);
      div_pulse("resume");
      chk("resume_count", 32'(cycle_count), 6);

      // step with bouncy press and release
      run_sw = 1'b0;
      tick();
      chk("step_idle", 32'(running), 0);
      seen = 0;
      step_btn = 1'b1;
      count_ce(1, c);
      seen += c;
      step_btn = 1'b0;
      count_ce(1, c);
      seen += c;
      step_btn = 1'b1;
      count_ce(11, c);
      seen += c;
      chk("step_press_ce", 32'(seen), 1);
      chk("step_count", 32'(cycle_count), 7);
      seen = 0;
      step_btn = 1'b0;
      count_ce(1, c);
      seen += c;
      step_btn = 1'b1;
      count_ce(1, c);
      seen += c;
      step_btn = 1'b0;
      count_ce(12, c);
      seen += c;
      chk("step_release_ce", 32'(seen), 0);
      chk("step_release_count", 32'(cycle_count), 7);

      // counter wrap: 16 -> 0, 17 -> 1
      run_sw = 1'b1;
      tick();
      for (int i = 0; i < 9; i++) div_pulse("wrap");
      chk("wrap_zero", 32'(cycle_count), 0);
      div_pulse("wrap_last");
      chk("wrap_one", 32'(cycle_count), 1);

      // reset while a step is pending
      run_sw = 1'b0;
      tick();
      step_btn = 1'b1;
      repeat (7) tick();
      rst = 1'b0;
      step_btn = 1'b0;
      tick();
      chk("midrst_ce", 32'(cpu_ce), 0);
      tick();
      rst = 1'b1;
      count_ce(12, c);
      chk("midrst_no_ce", 32'(c), 0);
      chk("midrst_running", 32'(running), 0);
      chk("midrst_halted", 32'(halted), 0);
      chk("midrst_count", 32'(cycle_count), 0);

`ifdef BREAKPOINT_EN
      bp_en = 1'b1;
      bp_addr = 32'h0040_0010;
      pc = 32'h0040_0010;
      run_sw = 1'b1;
      tick();
      chk("bp_run", 32'(running), 1);
      div_clk = 1'b1;
      tick();
      tick();
      tick();
      chk("bp_ce", 32'(cpu_ce), 1);
      tick();
      chk("bp_halted", 32'(halted), 1);
      chk("bp_hit", 32'(bp_hit), 1);
      chk("bp_ce_off", 32'(cpu_ce), 0);
      div_clk = 1'b0;
      count_ce(4, c);
      seen = c;
      div_clk = 1'b1;
      count_ce(4, c);
      seen += c;
      div_clk = 1'b0;
      count_ce(4, c);
      seen += c;
      chk("bp_no_more_ce", 32'(seen), 0);
      chk("bp_count", 32'(cycle_count), 1);
      bp_en = 1'b0;
      clr_halt = 1'b1;
      tick();
      clr_halt = 1'b0;
      chk("bp_hit_clr", 32'(bp_hit), 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
